multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the RV32I core datapath.
- Steps each instruction through FETCH / DECODE / EXEC / MEM / WB.
- Drives the IR, PC, register-file, memory-handshake and mux-select strobes consumed by the immediate generator, ALU and writeback muxes.
- Keeps cycle and retired-instruction counters that feed the CPI measurements.

---
 rtl/core_ctrl_pkg.sv | 83 ++++++++
 rtl/ctrl_perf_cnt.sv | 45 ++++
 rtl/multicycle_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg
// Shared definitions for the RV32I multi-cycle control path: sequencer
// states, RV32I major opcodes, opcode classes and the pc_sel / wb_sel
// mux codes. The immediate generator imports the same opcode constants,
// so an opcode only ever has to be edited here.
package core_ctrl_pkg;

  // Sequencer states. The encoding is visible on state_o, so keep it fixed.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Compact opcode class latched in DECODE. Zero is the reset value.
  typedef enum logic [3:0] {
    CLS_OPIMM  = 4'd0,
    CLS_OP     = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_AUIPC  = 4'd8
  } opclass_e;

  // pc_sel codes
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_BR    = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  // wb_sel codes
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  typedef struct packed {
    logic     valid;
    opclass_e cls;
  } opc_dec_t;

  // Maps a major opcode to its class; valid=0 flags an unsupported opcode.
  function automatic opc_dec_t decode_opcode(input logic [6:0] opc);
    opc_dec_t d;
    d.valid = 1'b1;
    d.cls   = CLS_OPIMM;
    case (opc)
      OPC_OPIMM:  d.cls = CLS_OPIMM;
      OPC_OP:     d.cls = CLS_OP;
      OPC_LOAD:   d.cls = CLS_LOAD;
      OPC_STORE:  d.cls = CLS_STORE;
      OPC_BRANCH: d.cls = CLS_BRANCH;
      OPC_JAL:    d.cls = CLS_JAL;
      OPC_JALR:   d.cls = CLS_JALR;
      OPC_LUI:    d.cls = CLS_LUI;
      OPC_AUIPC:  d.cls = CLS_AUIPC;
      default:    d.valid = 1'b0;
    endcase
    return d;
  endfunction

  // Only register-register ALU ops and branch compares use rs2 as operand B.
  function automatic logic uses_imm(input opclass_e c);
    return !(c == CLS_OP || c == CLS_BRANCH);
  endfunction

endpackage

// File: rtl/ctrl_perf_cnt.sv
// ctrl_perf_cnt
// Free-running performance counter used for the cycle and instret counts.
//   clk   in   core clock
//   rst   in   synchronous active-high clear
//   en    in   count this cycle
//   count out  W-bit counter value
// SAT=1 makes the counter stick at all-ones; SAT=0 lets it wrap to zero.
module ctrl_perf_cnt #(
  parameter int W   = 32,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: hold when idle or pinned at all-ones in saturating mode;
  // otherwise add one and let the natural W-bit overflow wrap to zero.
  always_comb begin
    count_d = count_q;
    if (en) begin
      if (SAT && (&count_q)) begin
        count_d = count_q;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  // Counter register; reset clears it regardless of en.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Multi-cycle RV32I sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
//   clk, rst             clock, synchronous active-high reset
//   instr                instruction register contents (valid from DECODE)
//   mem_ready            memory finishes the current request this cycle
//   br_taken             branch compare result, valid in EXEC
//   mem_req, mem_we      memory request / data write strobe
//   ir_we, pc_we         instruction register and PC write enables
//   pc_sel, wb_sel       PC source and writeback source selects
//   alu_src_imm, reg_we  ALU operand B select, register-file write
//   retire               one-cycle pulse per completed instruction
//   illegal              sticky unsupported-opcode flag
//   state_o              current state encoding
//   cycle_cnt            cycles since reset
//   instret_cnt          instructions retired since reset
module multicycle_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter bit SAT_CNT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             br_taken,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             alu_src_imm,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             retire,
  output logic             illegal,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_e   state_q, state_d;
  opclass_e cls_q, cls_d;
  logic     illegal_q, illegal_d;
  opc_dec_t dec;

  logic mem_req_c, mem_we_c, ir_we_c, pc_we_c, reg_we_c, retire_c;

  // Only the major opcode steers the sequencer; the rest is for the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[31:7];

  assign dec = decode_opcode(instr[6:0]);

  // Next-state and output decode. Strobes depend only on the current state,
  // the latched opcode class and the handshake inputs, so they are valid
  // early in the cycle. Selects are don't-care while their strobe is low.
  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    illegal_d   = illegal_q;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    ir_we_c     = 1'b0;
    pc_we_c     = 1'b0;
    reg_we_c    = 1'b0;
    retire_c    = 1'b0;
    pc_sel      = PC_PLUS4;
    wb_sel      = WB_ALU;
    alu_src_imm = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (dec.valid) begin
          cls_d   = dec.cls;
          state_d = ST_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = ST_TRAP;
        end
      end

      ST_EXEC: begin
        alu_src_imm = uses_imm(cls_q);
        if (cls_q == CLS_BRANCH) begin
          pc_we_c  = 1'b1;
          retire_c = 1'b1;
          pc_sel   = br_taken ? PC_BR : PC_PLUS4;
          state_d  = ST_FETCH;
        end else if (cls_q == CLS_LOAD || cls_q == CLS_STORE) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end

      // The ALU keeps producing the effective address while memory stalls.
      ST_MEM: begin
        alu_src_imm = uses_imm(cls_q);
        mem_req_c   = 1'b1;
        mem_we_c    = (cls_q == CLS_STORE);
        if (mem_ready) begin
          if (cls_q == CLS_STORE) begin
            pc_we_c  = 1'b1;
            retire_c = 1'b1;
            pc_sel   = PC_PLUS4;
            state_d  = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        alu_src_imm = uses_imm(cls_q);
        reg_we_c    = 1'b1;
        pc_we_c     = 1'b1;
        retire_c    = 1'b1;
        state_d     = ST_FETCH;
        case (cls_q)
          CLS_LOAD: wb_sel = WB_MEM;
          CLS_JAL:  wb_sel = WB_PC4;
          CLS_JALR: wb_sel = WB_PC4;
          CLS_LUI:  wb_sel = WB_IMM;
          default:  wb_sel = WB_ALU;
        endcase
        case (cls_q)
          CLS_JAL:  pc_sel = PC_BR;
          CLS_JALR: pc_sel = PC_JALR;
          default:  pc_sel = PC_PLUS4;
        endcase
      end

      // Parked until reset; nothing is requested or written.
      ST_TRAP: begin
        state_d = ST_TRAP;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State, class and sticky illegal flag. Reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      cls_q     <= CLS_OPIMM;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      illegal_q <= illegal_d;
    end
  end

  // A reset cycle must never leak a request or a write to the datapath.
  assign mem_req = mem_req_c & ~rst;
  assign mem_we  = mem_we_c  & ~rst;
  assign ir_we   = ir_we_c   & ~rst;
  assign pc_we   = pc_we_c   & ~rst;
  assign reg_we  = reg_we_c  & ~rst;
  assign retire  = retire_c  & ~rst;
  assign illegal = illegal_q;
  assign state_o = state_q;

  ctrl_perf_cnt #(.W(CNT_W), .SAT(SAT_CNT)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .count (cycle_cnt)
  );

  ctrl_perf_cnt #(.W(CNT_W), .SAT(SAT_CNT)) u_instret_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (retire),
    .count (instret_cnt)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
// Drives three copies of the sequencer (32-bit wrapping counters, 4-bit
// wrapping, 4-bit saturating) with the same stimulus. Each instruction is
// expanded into the cycle-by-cycle output trace it should produce, and a
// negedge process compares every copy against that trace.
module tb_multicycle_ctrl;

  localparam int K_OPIMM = 0, K_OP = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4,
                 K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8;

  typedef struct {
    logic        rdy;
    logic        br;
    logic [31:0] ins;
    logic [2:0]  st;
    logic        req, we, irwe, pcwe, regwe, ret, ill, alu;
    logic [1:0]  pcsel, wbsel;
    bit          chk_alu, chk_wb;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready, br_taken;

  logic        mem_req, mem_we, ir_we, pc_we, alu_src_imm, reg_we, retire, illegal;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  state_o;
  logic [31:0] cycle_cnt, instret_cnt;

  logic        w_req, w_we, w_irwe, w_pcwe, w_alu, w_regwe, w_ret, w_ill;
  logic [1:0]  w_pcsel, w_wbsel;
  logic [2:0]  w_st;
  logic [3:0]  w_cyc, w_inst;

  logic        s_req, s_we, s_irwe, s_pcwe, s_alu, s_regwe, s_ret, s_ill;
  logic [1:0]  s_pcsel, s_wbsel;
  logic [2:0]  s_st;
  logic [3:0]  s_cyc, s_inst;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_m   = 0;
  int   ret_m   = 0;
  cyc_t exp_e;
  bit   exp_rst;
  bit   exp_valid = 1'b0;
  int   exp_cyc, exp_ret;
  cyc_t trace[$];
  logic [6:0] opc_tab [9] = '{7'b0010011, 7'b0110011, 7'b0000011, 7'b0100011,
                              7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                              7'b0010111};

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(32), .SAT_CNT(1'b0)) u_dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .br_taken(br_taken),
    .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .alu_src_imm(alu_src_imm), .reg_we(reg_we), .wb_sel(wb_sel), .retire(retire),
    .illegal(illegal), .state_o(state_o), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  multicycle_ctrl #(.CNT_W(4), .SAT_CNT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .br_taken(br_taken),
    .mem_req(w_req), .mem_we(w_we), .ir_we(w_irwe), .pc_we(w_pcwe), .pc_sel(w_pcsel),
    .alu_src_imm(w_alu), .reg_we(w_regwe), .wb_sel(w_wbsel), .retire(w_ret),
    .illegal(w_ill), .state_o(w_st), .cycle_cnt(w_cyc), .instret_cnt(w_inst)
  );

  multicycle_ctrl #(.CNT_W(4), .SAT_CNT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .br_taken(br_taken),
    .mem_req(s_req), .mem_we(s_we), .ir_we(s_irwe), .pc_we(s_pcwe), .pc_sel(s_pcsel),
    .alu_src_imm(s_alu), .reg_we(s_regwe), .wb_sel(s_wbsel), .retire(s_ret),
    .illegal(s_ill), .state_o(s_st), .cycle_cnt(s_cyc), .instret_cnt(s_inst)
  );

  // Single comparison point; prints a FAIL line on any difference.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int kind_of(input logic [6:0] o);
    case (o)
      7'b0010011: return K_OPIMM;
      7'b0110011: return K_OP;
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b1100011: return K_BR;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      default:    return -1;
    endcase
  endfunction

  // Idle cycle: random don't-care inputs, every output expected low.
  function automatic cyc_t blank();
    cyc_t e;
    logic [31:0] r;
    r = $urandom;
    e.rdy = r[0]; e.br = r[1]; e.ins = '0; e.st = 3'd0;
    e.req = 0; e.we = 0; e.irwe = 0; e.pcwe = 0; e.regwe = 0; e.ret = 0; e.ill = 0; e.alu = 0;
    e.pcsel = 0; e.wbsel = 0; e.chk_alu = 0; e.chk_wb = 0;
    return e;
  endfunction

  function automatic logic [14:0] pk(input logic [2:0] st, input logic req, we, irwe, pcwe,
                                     input logic [1:0] pcsel, input logic alu, regwe,
                                     input logic [1:0] wbsel, input logic ret, ill);
    return {st, req, we, irwe, pcwe, pcsel, alu, regwe, wbsel, ret, ill};
  endfunction

  // Expands one instruction into the per-cycle trace it must produce:
  // fw fetch wait cycles, mw data wait cycles, trap_len cycles if illegal.
  task automatic buildTrace(input logic [31:0] ins, input int fw, input int mw,
                            input bit br, input int trap_len);
    cyc_t e;
    logic [31:0] junk;
    int k;
    k = kind_of(ins[6:0]);
    for (int i = 0; i <= fw; i++) begin
      e = blank(); junk = $urandom; e.ins = junk;
      e.st = 3'd0; e.req = 1; e.rdy = (i == fw); e.irwe = (i == fw);
      trace.push_back(e);
    end
    e = blank(); e.ins = ins; e.st = 3'd1;
    trace.push_back(e);
    if (k < 0) begin
      for (int i = 0; i < trap_len; i++) begin
        e = blank(); e.ins = ins; e.st = 3'd7; e.ill = 1;
        trace.push_back(e);
      end
      return;
    end
    e = blank(); e.ins = ins; e.st = 3'd2; e.chk_alu = 1;
    e.alu = (k != K_OP && k != K_BR);
    if (k == K_BR) begin
      e.br = br; e.pcwe = 1; e.ret = 1; e.pcsel = br ? 2'd1 : 2'd0;
      trace.push_back(e);
      return;
    end
    trace.push_back(e);
    if (k == K_LOAD || k == K_STORE) begin
      for (int i = 0; i <= mw; i++) begin
        e = blank(); e.ins = ins; e.st = 3'd3; e.req = 1; e.we = (k == K_STORE);
        e.rdy = (i == mw);
        if (i == mw && k == K_STORE) begin e.pcwe = 1; e.ret = 1; e.pcsel = 2'd0; end
        trace.push_back(e);
      end
      if (k == K_STORE) return;
    end
    e = blank(); e.ins = ins; e.st = 3'd4; e.regwe = 1; e.pcwe = 1; e.ret = 1;
    e.chk_alu = 1; e.alu = (k != K_OP); e.chk_wb = 1;
    e.wbsel = (k == K_LOAD) ? 2'd1 : (k == K_JAL || k == K_JALR) ? 2'd2 : (k == K_LUI) ? 2'd3 : 2'd0;
    e.pcsel = (k == K_JAL) ? 2'd1 : (k == K_JALR) ? 2'd2 : 2'd0;
    trace.push_back(e);
  endtask

  // Drives one cycle and publishes its expectation, then advances the
  // counter model across the clock edge.
  task automatic applyStimulus(input cyc_t e, input bit r);
    rst = r; mem_ready = e.rdy; br_taken = e.br; instr = e.ins;
    exp_e = e; exp_rst = r; exp_cyc = cyc_m; exp_ret = ret_m; exp_valid = 1'b1;
    @(posedge clk); #1;
    if (r) begin
      cyc_m = 0; ret_m = 0;
    end else begin
      cyc_m++;
      if (e.ret) ret_m++;
    end
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) applyStimulus(blank(), 1'b1);
  endtask

  task automatic runTrace(input int from, input int upto);
    for (int i = from; i < upto && i < trace.size(); i++) applyStimulus(trace[i], 1'b0);
  endtask

  task automatic playInstr(input logic [31:0] ins, input int fw, input int mw, input bit br);
    buildTrace(ins, fw, mw, br, 0);
    runTrace(0, trace.size());
    trace.delete();
  endtask

  // Per-cycle comparison of all three copies against the published trace.
  always @(negedge clk) begin
    if (exp_valid) begin
      if (exp_rst) begin
        checkOutput("rst_strobes", {26'd0, mem_req, mem_we, ir_we, pc_we, reg_we, retire}, 32'd0);
        checkOutput("rst_strobes_small", {26'd0, w_req | s_req, w_we | s_we, w_irwe | s_irwe,
                    w_pcwe | s_pcwe, w_regwe | s_regwe, w_ret | s_ret}, 32'd0);
      end else begin
        logic [14:0] m, ev;
        checkOutput("state_o", {29'd0, state_o}, {29'd0, exp_e.st});
        checkOutput("mem_req", {31'd0, mem_req}, {31'd0, exp_e.req});
        checkOutput("mem_we", {31'd0, mem_we}, {31'd0, exp_e.we});
        checkOutput("ir_we", {31'd0, ir_we}, {31'd0, exp_e.irwe});
        checkOutput("pc_we", {31'd0, pc_we}, {31'd0, exp_e.pcwe});
        checkOutput("reg_we", {31'd0, reg_we}, {31'd0, exp_e.regwe});
        checkOutput("retire", {31'd0, retire}, {31'd0, exp_e.ret});
        checkOutput("illegal", {31'd0, illegal}, {31'd0, exp_e.ill});
        if (exp_e.pcwe) checkOutput("pc_sel", {30'd0, pc_sel}, {30'd0, exp_e.pcsel});
        if (exp_e.chk_wb) checkOutput("wb_sel", {30'd0, wb_sel}, {30'd0, exp_e.wbsel});
        if (exp_e.chk_alu) checkOutput("alu_src_imm", {31'd0, alu_src_imm}, {31'd0, exp_e.alu});
        checkOutput("cycle_cnt", cycle_cnt, exp_cyc);
        checkOutput("instret_cnt", instret_cnt, exp_ret);
        m = 15'h7FFF;
        if (!exp_e.chk_alu) m[5] = 1'b0;
        if (!exp_e.pcwe) m[7:6] = 2'b00;
        if (!exp_e.chk_wb) m[3:2] = 2'b00;
        ev = pk(exp_e.st, exp_e.req, exp_e.we, exp_e.irwe, exp_e.pcwe, exp_e.pcsel,
                exp_e.alu, exp_e.regwe, exp_e.wbsel, exp_e.ret, exp_e.ill);
        checkOutput("wrap_outputs", {17'd0, pk(w_st, w_req, w_we, w_irwe, w_pcwe, w_pcsel,
                    w_alu, w_regwe, w_wbsel, w_ret, w_ill) & m}, {17'd0, ev & m});
        checkOutput("sat_outputs", {17'd0, pk(s_st, s_req, s_we, s_irwe, s_pcwe, s_pcsel,
                    s_alu, s_regwe, s_wbsel, s_ret, s_ill) & m}, {17'd0, ev & m});
        checkOutput("wrap_cycle_cnt", {28'd0, w_cyc}, exp_cyc % 16);
        checkOutput("wrap_instret_cnt", {28'd0, w_inst}, exp_ret % 16);
        checkOutput("sat_cycle_cnt", {28'd0, s_cyc}, (exp_cyc > 15) ? 15 : exp_cyc);
        checkOutput("sat_instret_cnt", {28'd0, s_inst}, (exp_ret > 15) ? 15 : exp_ret);
      end
    end
  end

  // Hard time limit so the run always ends with a summary.
  initial begin
    #400000;
    n_fail++;
    $display("[TB] FAIL timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    cyc_t e;
    logic [31:0] rnd, ins;
    logic [6:0] opc;
    int cut;
    rst = 1'b1; instr = '0; mem_ready = 1'b0; br_taken = 1'b0;
    @(posedge clk); #1;
    doReset(2);

    // addi x1,x0,5 with memory always ready
    playInstr(32'h00500093, 0, 0, 1'b0);
    checkOutput("addi_cycle_cnt", cycle_cnt, 32'd4);
    checkOutput("addi_instret_cnt", instret_cnt, 32'd1);
    checkOutput("addi_state_after", {29'd0, state_o}, 32'd0);

    // beq taken then not taken
    playInstr(32'h00000063, 0, 0, 1'b1);
    playInstr(32'h00000063, 0, 0, 1'b0);
    checkOutput("beq_cycle_cnt", cycle_cnt, 32'd10);
    checkOutput("beq_instret_cnt", instret_cnt, 32'd3);

    // lw with 3 fetch waits and 2 data waits
    doReset(2);
    playInstr(32'h0000A083, 3, 2, 1'b0);
    checkOutput("lw_cycle_cnt", cycle_cnt, 32'd10);
    checkOutput("lw_instret_cnt", instret_cnt, 32'd1);

    // sw
    playInstr(32'h0020A023, 0, 0, 1'b0);

    // lw aborted by reset while in MEM
    buildTrace(32'h0000A083, 0, 3, 1'b0, 0);
    runTrace(0, 5);
    trace.delete();
    doReset(2);
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    checkOutput("abort_state", {29'd0, state_o}, 32'd0);
    checkOutput("abort_mem_req", {31'd0, mem_req}, 32'd1);
    checkOutput("abort_cycle_cnt", cycle_cnt, 32'd0);
    checkOutput("abort_reg_we", {31'd0, reg_we}, 32'd0);
    playInstr(32'h00500093, 0, 0, 1'b0);

    // illegal opcode 0x7F, then long enough in TRAP to wrap 4-bit counters
    doReset(2);
    buildTrace(32'h0000007F, 0, 0, 1'b0, 20);
    runTrace(0, 2);
    checkOutput("trap_state", {29'd0, state_o}, 32'd7);
    checkOutput("trap_illegal", {31'd0, illegal}, 32'd1);
    checkOutput("trap_mem_req", {31'd0, mem_req}, 32'd0);
    runTrace(2, trace.size());
    trace.delete();
    checkOutput("trap_cycle_cnt", cycle_cnt, 32'd22);
    checkOutput("trap_wrap_cnt", {28'd0, w_cyc}, 32'd6);
    checkOutput("trap_sat_cnt", {28'd0, s_cyc}, 32'd15);
    doReset(2);

    // Randomised instruction mix with waits, traps and mid-instruction resets
    for (int t = 0; t < 120; t++) begin
      cut = $urandom_range(0, 9);
      if (cut < 9) begin
        opc = opc_tab[cut];
      end else begin
        do begin
          rnd = $urandom;
          opc = rnd[6:0];
        end while (kind_of(opc) >= 0);
      end
      rnd = $urandom;
      ins = {rnd[31:7], opc};
      buildTrace(ins, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                 $urandom_range(10, 20));
      if ($urandom_range(0, 7) == 0) begin
        cut = $urandom_range(1, trace.size() - 1);
        runTrace(0, cut);
        trace.delete();
        doReset($urandom_range(1, 2));
      end else begin
        runTrace(0, trace.size());
        trace.delete();
        if (kind_of(opc) < 0) doReset(2);
      end
    end

    e = blank();
    applyStimulus(e, 1'b1);
    exp_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
